// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg
// Shared constants and helpers for the dff_pipe register pipeline.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default payload width and stage count
//   occ_width(depth)              : bits needed to count 0..depth valid stages
package dff_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Occupancy has to represent the full state (all DEPTH stages valid),
  // hence DEPTH+1 distinct values.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// dff_pipe_if
// Valid/ready bundle around a dff_pipe instance.
//   flush                         : synchronous clear of every stage valid
//   in_valid / in_ready / in_data : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and payload
//   occupancy                     : number of valid stages
// Modports:
//   master : the side that feeds and drains the pipe
//   slave  : the pipe itself
interface dff_pipe_if #(
  parameter int WIDTH = dff_pipe_pkg::DEFAULT_WIDTH,
  parameter int DEPTH = dff_pipe_pkg::DEFAULT_DEPTH
);
  import dff_pipe_pkg::*;

  localparam int OCC_W = occ_width(DEPTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage
// One valid+data register of the dff_pipe chain.
//   clk, rst    : clock and synchronous active-high reset
//   flush       : synchronous clear of the valid bit
//   up_valid    : valid of the predecessor (or of the pipe input for stage 0)
//   up_data     : data of the predecessor (or of the pipe input)
//   down_ready  : ready term of the successor (or out_ready for the last stage)
//   ready       : this stage's ready term, !valid | down_ready
//   valid, data : registered stage contents
// Build option DFF_PIPE_DATA_RST_EN: when defined, rst also loads data with
// RST_VAL and flush leaves data untouched; when undefined the data register
// has no reset at all.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // An empty stage always accepts, which is what collapses bubbles
  // toward the output while the downstream is stalled.
  assign ready = ~valid | down_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
    end
  end

  // Data only moves when a real item arrives; an incoming bubble clears
  // valid but keeps the old payload to avoid needless toggling.
`ifdef DFF_PIPE_DATA_RST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= RST_VAL;
    end else if (!flush && ready && up_valid) begin
      data <= up_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (ready && up_valid) begin
      data <= up_data;
    end
  end
`endif

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe
// Parametrised register pipeline with per-stage valids, valid/ready
// backpressure, bubble collapsing, synchronous flush and occupancy count.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (clears all stage valids)
//   bus : dff_pipe_if slave modport (flush, in_*, out_*, occupancy)
// Parameters: WIDTH data bits, DEPTH stages, RST_VAL data reset value.
// Build option DFF_PIPE_DATA_RST_EN: data registers also reset to RST_VAL.
// Stage DEPTH-1 is the output stage; stage 0 takes the pipe input.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter int               DEPTH   = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic       clk,
  input logic       rst,
  dff_pipe_if.slave bus
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [OCC_W-1:0] occ;

  // Each stage keeps its own ready wire so the out_ready -> in_ready
  // chain is a plain series of gates rather than one self-referencing vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             ready;
    logic             up_valid;
    logic             down_ready;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = v[i-1];
      assign up_data  = d[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign down_ready = bus.out_ready;
    end else begin : g_link
      assign down_ready = g_stage[i+1].ready;
    end

    dff_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.flush),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (down_ready),
      .ready      (ready),
      .valid      (v[i]),
      .data       (d[i])
    );
  end

  // Flush blocks acceptance so an item offered in the flush cycle is
  // refused at the handshake rather than silently swallowed.
  assign bus.in_ready  = g_stage[0].ready & ~bus.flush;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];

  // Popcount of the registered valids only, so occupancy has no
  // combinational path from any input.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(v[i]);
    end
  end

  assign bus.occupancy = occ;

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe
// Self-checking bench for dff_pipe with WIDTH=8, DEPTH=4.
// A table of per-cycle vectors covers reset, streaming and backpressure;
// hand-written sequences cover bubble collapse, flush collision and
// reset in the middle of a stream.
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       chk;
    logic       exp_in_ready;
    logic       exp_out_valid;
    logic [7:0] exp_out_data;
    logic [2:0] exp_occ;
  } vec_t;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;
  vec_t vecs[$];

  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_if ();

  dff_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string what, input logic [7:0] act, input logic [7:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [7:0] id, input logic ordy);
    rst              = r;
    bus_if.flush     = f;
    bus_if.in_valid  = iv;
    bus_if.in_data   = id;
    bus_if.out_ready = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic eir, input logic eov,
                             input logic [7:0] eod, input logic [2:0] eocc);
    compare({tag, ".in_ready"}, {7'd0, bus_if.in_ready}, {7'd0, eir});
    compare({tag, ".out_valid"}, {7'd0, bus_if.out_valid}, {7'd0, eov});
    compare({tag, ".occupancy"}, {5'd0, bus_if.occupancy}, {5'd0, eocc});
    if (eov) compare({tag, ".out_data"}, bus_if.out_data, eod);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic r, input logic f, input logic iv,
                      input logic [7:0] id, input logic ordy, input logic eir,
                      input logic eov, input logic [7:0] eod, input logic [2:0] eocc);
    applyStimulus(r, f, iv, id, ordy);
    checkOutput(tag, eir, eov, eod, eocc);
    tick();
  endtask

  task automatic addVec(input logic r, input logic f, input logic iv, input logic [7:0] id,
                        input logic ordy, input logic chk, input logic eir, input logic eov,
                        input logic [7:0] eod, input logic [2:0] eocc);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.in_data = id; v.out_ready = ordy;
    v.chk = chk; v.exp_in_ready = eir; v.exp_out_valid = eov;
    v.exp_out_data = eod; v.exp_occ = eocc;
    vecs.push_back(v);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    // Expected values describe the state before each edge; in_ready is
    // the combinational answer to that vector's inputs.
    //     rst  fl  iv  data   ordy chk  eir eov eod    occ
    // reset for two cycles with an item offered
    addVec(1, 0, 1, 8'hEE, 1, 0, 0, 0, 8'h00, 3'd0);
    addVec(1, 0, 1, 8'hEE, 1, 1, 1, 0, 8'h00, 3'd0);
    addVec(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 3'd0);
    // streaming 01..08, first output three edges after acceptance
    addVec(0, 0, 1, 8'h01, 1, 1, 1, 0, 8'h00, 3'd0);
    addVec(0, 0, 1, 8'h02, 1, 1, 1, 0, 8'h00, 3'd1);
    addVec(0, 0, 1, 8'h03, 1, 1, 1, 0, 8'h00, 3'd2);
    addVec(0, 0, 1, 8'h04, 1, 1, 1, 0, 8'h00, 3'd3);
    addVec(0, 0, 1, 8'h05, 1, 1, 1, 1, 8'h01, 3'd4);
    addVec(0, 0, 1, 8'h06, 1, 1, 1, 1, 8'h02, 3'd4);
    addVec(0, 0, 1, 8'h07, 1, 1, 1, 1, 8'h03, 3'd4);
    addVec(0, 0, 1, 8'h08, 1, 1, 1, 1, 8'h04, 3'd4);
    addVec(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h05, 3'd4);
    addVec(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h06, 3'd3);
    addVec(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h07, 3'd2);
    addVec(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h08, 3'd1);
    // backpressure: offer 10..15 with out_ready low
    addVec(0, 0, 1, 8'h10, 0, 1, 1, 0, 8'h00, 3'd0);
    addVec(0, 0, 1, 8'h11, 0, 1, 1, 0, 8'h00, 3'd1);
    addVec(0, 0, 1, 8'h12, 0, 1, 1, 0, 8'h00, 3'd2);
    addVec(0, 0, 1, 8'h13, 0, 1, 1, 0, 8'h00, 3'd3);
    addVec(0, 0, 1, 8'h14, 0, 1, 0, 1, 8'h10, 3'd4);
    addVec(0, 0, 1, 8'h14, 0, 1, 0, 1, 8'h10, 3'd4);
    // release: full pass-through, then drain
    addVec(0, 0, 1, 8'h14, 1, 1, 1, 1, 8'h10, 3'd4);
    addVec(0, 0, 1, 8'h15, 1, 1, 1, 1, 8'h11, 3'd4);
    addVec(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h12, 3'd4);
    addVec(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h13, 3'd3);
    addVec(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h14, 3'd2);
    addVec(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h15, 3'd1);
    addVec(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 3'd0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].flush, vecs[k].in_valid,
                    vecs[k].in_data, vecs[k].out_ready);
      if (vecs[k].chk) begin
        checkOutput($sformatf("vec%0d", k), vecs[k].exp_in_ready,
                    vecs[k].exp_out_valid, vecs[k].exp_out_data, vecs[k].exp_occ);
      end
`ifdef DFF_PIPE_DATA_RST_EN
      if (k == 2) compare("vec2.rst_out_data", bus_if.out_data, 8'h00);
`endif
      tick();
    end

    // Bubble collapse: A0, two idle cycles, B0, then let them pack
    //    tag    rst fl iv data   ordy eir eov eod    occ
    step("bub0", 0, 0, 1, 8'hA0, 0, 1, 0, 8'h00, 3'd0);
    step("bub1", 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd1);
    step("bub2", 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd1);
    step("bub3", 0, 0, 1, 8'hB0, 0, 1, 0, 8'h00, 3'd1);
    step("bub4", 0, 0, 0, 8'h00, 0, 1, 1, 8'hA0, 3'd2);
    step("bub5", 0, 0, 0, 8'h00, 0, 1, 1, 8'hA0, 3'd2);
    step("bub6", 0, 0, 0, 8'h00, 1, 1, 1, 8'hA0, 3'd2);
    step("bub7", 0, 0, 0, 8'h00, 1, 1, 1, 8'hB0, 3'd1);
    step("bub8", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd0);

    // Flush collision with occupancy 3 and 0x55 offered
    step("fl0", 0, 0, 1, 8'h21, 0, 1, 0, 8'h00, 3'd0);
    step("fl1", 0, 0, 1, 8'h22, 0, 1, 0, 8'h00, 3'd1);
    step("fl2", 0, 0, 1, 8'h23, 0, 1, 0, 8'h00, 3'd2);
    step("fl3", 0, 1, 1, 8'h55, 0, 0, 0, 8'h00, 3'd3);
    step("fl4", 0, 0, 1, 8'h66, 1, 1, 0, 8'h00, 3'd0);
    step("fl5", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd1);
    step("fl6", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd1);
    step("fl7", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd1);
    step("fl8", 0, 0, 0, 8'h00, 1, 1, 1, 8'h66, 3'd1);
    step("fl9", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd0);

    // Reset during an output transfer with occupancy 3
    step("mr0", 0, 0, 1, 8'h31, 0, 1, 0, 8'h00, 3'd0);
    step("mr1", 0, 0, 1, 8'h32, 0, 1, 0, 8'h00, 3'd1);
    step("mr2", 0, 0, 1, 8'h33, 0, 1, 0, 8'h00, 3'd2);
    step("mr3", 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd3);
    step("mr4", 1, 0, 1, 8'h77, 1, 1, 1, 8'h31, 3'd3);
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("mr5", 1, 0, 8'h00, 3'd0);
`ifdef DFF_PIPE_DATA_RST_EN
    compare("mr5.rst_out_data", bus_if.out_data, 8'h00);
`endif
    tick();
    step("mr6",  0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd0);
    step("mr7",  0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd0);
    step("mr8",  0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd0);
    step("mr9",  0, 0, 1, 8'h88, 1, 1, 0, 8'h00, 3'd0);
    step("mr10", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd1);
    step("mr11", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd1);
    step("mr12", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd1);
    step("mr13", 0, 0, 0, 8'h00, 1, 1, 1, 8'h88, 3'd1);
    step("mr14", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
